// File: rtl/core_ex.sv
// core_ex: RV32I integer execute stage for R-type and I-type ALU instructions with registered write-back outputs.
// Optional feature macro SERIAL_SHIFT_EN: shifts run one bit per cycle in a SHIFT state instead of the barrel shifter.

module core_ex (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic        flush_in,
   input  logic [31:0] inst_in,
   input  logic [31:0] inst_addr_in,
   input  logic        reg_we_in,
   input  logic [4:0]  reg_write_addr_in,
   input  logic [31:0] reg1_data_in,
   input  logic [31:0] reg2_data_in,
   input  logic [31:0] opnum2_in,
   output logic        valid_out,
   output logic [31:0] inst_addr_out,
   output logic        reg_we_out,
   output logic [4:0]  reg_write_addr_out,
   output logic [31:0] reg_write_data_out
);

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t      r_state;
   logic        r_valid;
   logic        r_we;
   logic [4:0]  r_wAddr;
   logic [31:0] r_wData;
   logic [31:0] r_instAddr;
   logic [31:0] r_shData;
   logic [4:0]  r_shCount;
   logic        r_shLeft;
   logic        r_shArith;
   logic [31:0] r_pendAddr;
   logic [4:0]  r_pendRd;
   logic        r_pendWe;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_alt;
   logic        w_isR;
   logic        w_isI;
   logic        w_supported;
   logic [31:0] w_opA;
   logic [31:0] w_opB;
   logic [4:0]  w_shamt;
   logic        w_isShift;
   logic        w_serialStart;
   logic        w_accept;
   logic        w_rdWe;
   logic [31:0] w_result;
   logic [31:0] w_shNext;
   logic        w_unused;

   assign w_opcode    = inst_in[6:0];
   assign w_funct3    = inst_in[14:12];
   assign w_alt       = inst_in[30];
   assign w_isR       = (w_opcode == OP_R);
   assign w_isI       = (w_opcode == OP_I);
   assign w_supported = w_isR || w_isI;
   assign w_opA       = reg1_data_in;
   assign w_opB       = w_isR ? reg2_data_in : opnum2_in;
   assign w_shamt     = w_opB[4:0];
   assign w_isShift   = w_supported && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));
   assign w_rdWe      = reg_we_in && (reg_write_addr_in != 5'd0);
   assign w_accept    = valid_in && ready_out && !flush_in;
   assign ready_out   = (r_state == S_IDLE);

   // The instruction fields not decoded here (rs1/rs2/rd indices, funct7 apart from bit 30) arrive pre-resolved on other ports.
   assign w_unused = &{1'b0, inst_in[31], inst_in[29:15], inst_in[11:7]};

`ifdef SERIAL_SHIFT_EN
   assign w_serialStart = w_isShift && (w_shamt != 5'd0);
`else
   assign w_serialStart = 1'b0;
`endif

   // Single-cycle ALU; the ADD/SUB variant bit only applies to R-type because I-type bit 30 belongs to the immediate.
   always_comb begin
      w_result = 32'd0;
      if (w_supported) begin
         case (w_funct3)
            3'b000:  w_result = (w_isR && w_alt) ? (w_opA - w_opB) : (w_opA + w_opB);
            3'b001:  w_result = w_opA << w_shamt;
            3'b010:  w_result = {31'd0, ($signed(w_opA) < $signed(w_opB))};
            3'b011:  w_result = {31'd0, (w_opA < w_opB)};
            3'b100:  w_result = w_opA ^ w_opB;
            3'b101:  w_result = w_alt ? $unsigned($signed(w_opA) >>> w_shamt) : (w_opA >> w_shamt);
            3'b110:  w_result = w_opA | w_opB;
            default: w_result = w_opA & w_opB;
         endcase
      end
   end

   // One step of the serial shifter; arithmetic right shifts replicate bit 31.
   always_comb begin
      w_shNext = r_shData;
      if (r_shLeft) begin
         w_shNext = {r_shData[30:0], 1'b0};
      end else begin
         w_shNext = {(r_shArith ? r_shData[31] : 1'b0), r_shData[31:1]};
      end
   end

   // Control FSM and registered write-back. valid_out and reg_we_out default low so every completion is a single-cycle pulse,
   // while address and data hold their last values between completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_valid    <= 1'b0;
         r_we       <= 1'b0;
         r_wAddr    <= 5'd0;
         r_wData    <= 32'd0;
         r_instAddr <= 32'd0;
         r_shData   <= 32'd0;
         r_shCount  <= 5'd0;
         r_shLeft   <= 1'b0;
         r_shArith  <= 1'b0;
         r_pendAddr <= 32'd0;
         r_pendRd   <= 5'd0;
         r_pendWe   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_serialStart) begin
                     r_state    <= S_SHIFT;
                     r_shData   <= w_opA;
                     r_shCount  <= w_shamt;
                     r_shLeft   <= (w_funct3 == 3'b001);
                     r_shArith  <= w_alt;
                     r_pendAddr <= inst_addr_in;
                     r_pendRd   <= reg_write_addr_in;
                     r_pendWe   <= w_rdWe;
                  end else begin
                     r_valid    <= 1'b1;
                     r_we       <= w_supported && w_rdWe;
                     r_wAddr    <= reg_write_addr_in;
                     r_wData    <= w_result;
                     r_instAddr <= inst_addr_in;
                  end
               end
            end
            S_SHIFT: begin
               if (flush_in) begin
                  r_state <= S_IDLE;
               end else if (r_shCount == 5'd1) begin
                  r_state    <= S_IDLE;
                  r_shCount  <= 5'd0;
                  r_shData   <= w_shNext;
                  r_valid    <= 1'b1;
                  r_we       <= r_pendWe;
                  r_wAddr    <= r_pendRd;
                  r_wData    <= w_shNext;
                  r_instAddr <= r_pendAddr;
               end else begin
                  r_shCount <= r_shCount - 5'd1;
                  r_shData  <= w_shNext;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign valid_out          = r_valid;
   assign reg_we_out         = r_we;
   assign reg_write_addr_out = r_wAddr;
   assign reg_write_data_out = r_wData;
   assign inst_addr_out      = r_instAddr;

endmodule

// File: tb/tb_core_ex.sv
// tb_core_ex: directed self-checking bench for core_ex; shift latency and SHIFT-state scenarios follow SERIAL_SHIFT_EN.

module tb_core_ex;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [31:0] JUNK = 32'hDEADBEEF;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        ready_out;
   logic        flush_in;
   logic [31:0] inst_in;
   logic [31:0] inst_addr_in;
   logic        reg_we_in;
   logic [4:0]  reg_write_addr_in;
   logic [31:0] reg1_data_in;
   logic [31:0] reg2_data_in;
   logic [31:0] opnum2_in;
   logic        valid_out;
   logic [31:0] inst_addr_out;
   logic        reg_we_out;
   logic [4:0]  reg_write_addr_out;
   logic [31:0] reg_write_data_out;

   int total;
   int bad;

   core_ex dut (
      .clk                (clk),
      .rst                (rst),
      .valid_in           (valid_in),
      .ready_out          (ready_out),
      .flush_in           (flush_in),
      .inst_in            (inst_in),
      .inst_addr_in       (inst_addr_in),
      .reg_we_in          (reg_we_in),
      .reg_write_addr_in  (reg_write_addr_in),
      .reg1_data_in       (reg1_data_in),
      .reg2_data_in       (reg2_data_in),
      .opnum2_in          (opnum2_in),
      .valid_out          (valid_out),
      .inst_addr_out      (inst_addr_out),
      .reg_we_out         (reg_we_out),
      .reg_write_addr_out (reg_write_addr_out),
      .reg_write_data_out (reg_write_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mkInst(input logic [6:0] op, input logic [2:0] f3, input logic alt);
      return {1'b0, alt, 15'd0, f3, 5'd0, op};
   endfunction

   // Routes operand B to rs2 or the immediate port by opcode, with junk on the unused one.
   task automatic setOp(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input logic [31:0] addr);
      inst_in           = inst;
      reg1_data_in      = a;
      reg2_data_in      = (inst[6:0] == OP_I) ? JUNK : b;
      opnum2_in         = (inst[6:0] == OP_I) ? b : JUNK;
      reg_write_addr_in = rd;
      reg_we_in         = we;
      inst_addr_in      = addr;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      valid_in = 1'b0;
      flush_in = 1'b0;
      setOp(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
      total++; if (reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_we: got %b expected 0", reg_we_out); end
      total++; if (reg_write_addr_out !== 5'd0) begin bad++; $display("[TB] FAIL reset_waddr: got %h expected 0", reg_write_addr_out); end
      total++; if (reg_write_data_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_wdata: got %h expected 0", reg_write_data_out); end
      total++; if (inst_addr_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_iaddr: got %h expected 0", inst_addr_out); end
      rst = 1'b0;
      total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_out); end
   endtask

   task automatic test_add;
      setOp(mkInst(OP_R, 3'b000, 1'b0), 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1, 32'h0000_0100);
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL add_valid: got %b expected 1", valid_out); end
      total++; if (reg_we_out !== 1'b1) begin bad++; $display("[TB] FAIL add_we: got %b expected 1", reg_we_out); end
      total++; if (reg_write_addr_out !== 5'd5) begin bad++; $display("[TB] FAIL add_waddr: got %h expected 05", reg_write_addr_out); end
      total++; if (reg_write_data_out !== 32'h80000000) begin bad++; $display("[TB] FAIL add_wdata: got %h expected 80000000", reg_write_data_out); end
      total++; if (inst_addr_out !== 32'h100) begin bad++; $display("[TB] FAIL add_iaddr: got %h expected 00000100", inst_addr_out); end
      @(posedge clk); #1;
      total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL add_pulse: got %b expected 0", valid_out); end
      total++; if (reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL add_we_idle: got %b expected 0", reg_we_out); end
      total++; if (reg_write_data_out !== 32'h80000000) begin bad++; $display("[TB] FAIL add_hold: got %h expected 80000000", reg_write_data_out); end
   endtask

   // Non-shift ALU ops streamed with valid_in held high: one completion per cycle.
   task automatic test_back_to_back;
      logic [31:0] vInst [12];
      logic [31:0] vA [12];
      logic [31:0] vB [12];
      logic [31:0] vExp [12];
      vInst = '{mkInst(OP_R, 3'b000, 1'b1), mkInst(OP_R, 3'b010, 1'b0), mkInst(OP_R, 3'b011, 1'b0),
                mkInst(OP_R, 3'b100, 1'b0), mkInst(OP_R, 3'b110, 1'b0), mkInst(OP_R, 3'b111, 1'b0),
                mkInst(OP_I, 3'b000, 1'b0), mkInst(OP_I, 3'b010, 1'b0), mkInst(OP_I, 3'b011, 1'b0),
                mkInst(OP_I, 3'b100, 1'b0), mkInst(OP_I, 3'b000, 1'b1), mkInst(OP_I, 3'b111, 1'b0)};
      vA    = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'd1, 32'hFFFF0000};
      vB    = '{32'd7, 32'd1, 32'd1, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00,
                32'hFFFFFFFD, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h00000400, 32'h0000FFFF};
      vExp  = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000,
                32'd7, 32'd1, 32'd0, 32'hEDCBA987, 32'h00000401, 32'd0};
      valid_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         setOp(vInst[i], vA[i], vB[i], 5'(i + 1), 1'b1, 32'h2000 + 32'(i * 4));
         @(posedge clk); #1;
         total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, valid_out); end
         total++; if (reg_write_data_out !== vExp[i]) begin bad++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, reg_write_data_out, vExp[i]); end
         total++; if (reg_write_addr_out !== 5'(i + 1)) begin bad++; $display("[TB] FAIL b2b_waddr[%0d]: got %h expected %h", i, reg_write_addr_out, 5'(i + 1)); end
         total++; if (reg_we_out !== 1'b1) begin bad++; $display("[TB] FAIL b2b_we[%0d]: got %b expected 1", i, reg_we_out); end
         total++; if (inst_addr_out !== 32'h2000 + 32'(i * 4)) begin bad++; $display("[TB] FAIL b2b_iaddr[%0d]: got %h expected %h", i, inst_addr_out, 32'h2000 + 32'(i * 4)); end
      end
      valid_in = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_x0_and_unsupported;
      setOp(mkInst(OP_I, 3'b000, 1'b0), 32'd0, 32'd7, 5'd0, 1'b1, 32'h300);
      valid_in = 1'b1;
      @(posedge clk); #1;
      total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL x0_valid: got %b expected 1", valid_out); end
      total++; if (reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL x0_we: got %b expected 0", reg_we_out); end
      setOp(mkInst(OP_R, 3'b000, 1'b0), 32'd1, 32'd2, 5'd3, 1'b0, 32'h304);
      @(posedge clk); #1;
      total++; if (reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL we_in_low: got %b expected 0", reg_we_out); end
      total++; if (reg_write_data_out !== 32'd3) begin bad++; $display("[TB] FAIL we_in_low_data: got %h expected 00000003", reg_write_data_out); end
      setOp(mkInst(OP_LD, 3'b010, 1'b0), 32'd5, 32'd9, 5'd4, 1'b1, 32'h308);
      @(posedge clk); #1;
      valid_in = 1'b0;
      total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL unsup_valid: got %b expected 1", valid_out); end
      total++; if (reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL unsup_we: got %b expected 0", reg_we_out); end
      total++; if (reg_write_data_out !== 32'd0) begin bad++; $display("[TB] FAIL unsup_data: got %h expected 0", reg_write_data_out); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush;
      setOp(mkInst(OP_R, 3'b000, 1'b0), 32'd2, 32'd3, 5'd6, 1'b1, 32'h400);
      valid_in = 1'b1;
      @(posedge clk); #1;
      setOp(mkInst(OP_R, 3'b000, 1'b1), 32'd9, 32'd1, 5'd7, 1'b1, 32'h404);
      flush_in = 1'b1;
      @(posedge clk); #1;
      flush_in = 1'b0;
      valid_in = 1'b0;
      total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b expected 0", valid_out); end
      total++; if (reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL flush_we: got %b expected 0", reg_we_out); end
      total++; if (reg_write_data_out !== 32'd5) begin bad++; $display("[TB] FAIL flush_hold: got %h expected 00000005", reg_write_data_out); end
      total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %b expected 1", ready_out); end
   endtask

   task automatic test_reset_priority;
      setOp(mkInst(OP_R, 3'b000, 1'b0), 32'd20, 32'd22, 5'd9, 1'b1, 32'h500);
      valid_in = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      valid_in = 1'b0;
      total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL rstpri_valid: got %b expected 0", valid_out); end
      total++; if (reg_write_data_out !== 32'd0) begin bad++; $display("[TB] FAIL rstpri_data: got %h expected 0", reg_write_data_out); end
      total++; if (reg_write_addr_out !== 5'd0) begin bad++; $display("[TB] FAIL rstpri_waddr: got %h expected 0", reg_write_addr_out); end
      total++; if (inst_addr_out !== 32'd0) begin bad++; $display("[TB] FAIL rstpri_iaddr: got %h expected 0", inst_addr_out); end
   endtask

   // Shifts: cycles to completion and ready-low cycles equal shamt in the serial build, zero with the barrel shifter.
   task automatic test_shift;
      logic [31:0] vInst [7];
      logic [31:0] vA [7];
      logic [31:0] vB [7];
      logic [31:0] vExp [7];
      int          vSh [7];
      int          n;
      int          low;
      int          expLat;
      vInst = '{mkInst(OP_R, 3'b001, 1'b0), mkInst(OP_R, 3'b101, 1'b0), mkInst(OP_R, 3'b101, 1'b1),
                mkInst(OP_I, 3'b101, 1'b1), mkInst(OP_I, 3'b101, 1'b0), mkInst(OP_I, 3'b001, 1'b0),
                mkInst(OP_R, 3'b101, 1'b1)};
      vA    = '{32'd1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0000ABCD, 32'h40000000};
      vB    = '{32'hFFFFFF24, 32'd4, 32'd4, 32'h00000404, 32'h0000001F, 32'd0, 32'd2};
      vExp  = '{32'h00000010, 32'h08000000, 32'hF8000000, 32'hF8000000, 32'h00000001, 32'h0000ABCD, 32'h10000000};
      vSh   = '{4, 4, 4, 4, 31, 0, 2};
      for (int i = 0; i < 7; i++) begin
         setOp(vInst[i], vA[i], vB[i], 5'(i + 10), 1'b1, 32'h600 + 32'(i * 4));
         valid_in = 1'b1;
         @(posedge clk); #1;
         valid_in = 1'b0;
         n = 0;
         low = 0;
         while (valid_out !== 1'b1 && n < 40) begin
            if (ready_out === 1'b0) low++;
            @(posedge clk); #1;
            n++;
         end
`ifdef SERIAL_SHIFT_EN
         expLat = vSh[i];
`else
         expLat = 0;
`endif
         total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL shift_done[%0d]: got %b expected 1", i, valid_out); end
         total++; if (reg_write_data_out !== vExp[i]) begin bad++; $display("[TB] FAIL shift_data[%0d]: got %h expected %h", i, reg_write_data_out, vExp[i]); end
         total++; if (reg_write_addr_out !== 5'(i + 10)) begin bad++; $display("[TB] FAIL shift_waddr[%0d]: got %h expected %h", i, reg_write_addr_out, 5'(i + 10)); end
         total++; if (n != expLat) begin bad++; $display("[TB] FAIL shift_latency[%0d]: got %0d expected %0d", i, n, expLat); end
         total++; if (low != expLat) begin bad++; $display("[TB] FAIL shift_ready_low[%0d]: got %0d expected %0d", i, low, expLat); end
         total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL shift_ready_after[%0d]: got %b expected 1", i, ready_out); end
      end
   endtask

`ifdef SERIAL_SHIFT_EN
   task automatic test_flush_shift;
      int pulses;
      setOp(mkInst(OP_R, 3'b001, 1'b0), 32'd1, 32'd31, 5'd12, 1'b1, 32'h700);
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (ready_out !== 1'b0) begin bad++; $display("[TB] FAIL fshift_busy: got %b expected 0", ready_out); end
      flush_in = 1'b1;
      @(posedge clk); #1;
      flush_in = 1'b0;
      total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL fshift_ready: got %b expected 1", ready_out); end
      pulses = 0;
      for (int c = 0; c < 35; c++) begin
         if (valid_out === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      total++; if (pulses != 0) begin bad++; $display("[TB] FAIL fshift_no_valid: got %0d expected 0", pulses); end
      setOp(mkInst(OP_R, 3'b000, 1'b0), 32'd2, 32'd3, 5'd13, 1'b1, 32'h704);
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      total++; if (valid_out !== 1'b1 || reg_write_data_out !== 32'd5) begin bad++; $display("[TB] FAIL fshift_next_add: got %b/%h expected 1/00000005", valid_out, reg_write_data_out); end
   endtask

   task automatic test_reset_shift;
      int pulses;
      setOp(mkInst(OP_R, 3'b001, 1'b0), 32'd1, 32'd20, 5'd14, 1'b1, 32'h800);
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (valid_out !== 1'b0 || reg_we_out !== 1'b0) begin bad++; $display("[TB] FAIL rshift_ctrl: got %b/%b expected 0/0", valid_out, reg_we_out); end
      total++; if (reg_write_data_out !== 32'd0 || reg_write_addr_out !== 5'd0 || inst_addr_out !== 32'd0) begin bad++; $display("[TB] FAIL rshift_data: got %h/%h/%h expected 0/0/0", reg_write_data_out, reg_write_addr_out, inst_addr_out); end
      total++; if (ready_out !== 1'b1) begin bad++; $display("[TB] FAIL rshift_ready: got %b expected 1", ready_out); end
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (valid_out === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("[TB] FAIL rshift_no_valid: got %0d expected 0", pulses); end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_add();
      test_back_to_back();
      test_x0_and_unsupported();
      test_flush();
      test_reset_priority();
      test_shift();
`ifdef SERIAL_SHIFT_EN
      test_flush_shift();
      test_reset_shift();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
